// File: rtl/i2c_master_fifo_seq.sv
// I2C master front end: CPU register port, TX command FIFO, RX data FIFO and a
// sequencer that feeds i2c_master_byte_ctl one command at a time.
package i2c_master_fifo_seq_pkg;

  typedef struct packed {
    logic       nak;
    logic       read;
    logic       stop;
    logic       start;
    logic [7:0] data;
  } tx_entry_t;

  typedef enum logic [3:0] {
    CMD_IDLE     = 4'd0,
    CMD_START    = 4'd1,
    CMD_STOP     = 4'd2,
    CMD_WRITE    = 4'd3,
    CMD_READ_ACK = 4'd4,
    CMD_READ_NAK = 4'd5
  } cmd_t;

endpackage

module i2c_master_fifo_seq
  import i2c_master_fifo_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] PSC_RESET  = 16'd384
) (
  input  logic        i_sysclk,
  input  logic        i_reset_n,
  input  logic        i_wr_ena,
  input  logic [4:0]  i_wr_addr,
  input  logic [7:0]  i_wr_data,
  input  logic        i_rd_ena,
  input  logic [4:0]  i_rd_addr,
  output logic [7:0]  o_rd_data,
  output logic        o_read_ready,
  output logic        o_write_ready,
  output logic        o_interrupt,
  output logic        o_enable,
  output logic [15:0] o_prescale,
  output logic [3:0]  o_cmd,
  output logic        o_cmd_trig,
  output logic [7:0]  o_wr_data,
  input  logic        i_cmd_ack,
  input  logic        i_i2c_ack,
  input  logic        i_i2c_al,
  input  logic [7:0]  i_rx_data
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PSC_LO = 3'd1;
  localparam logic [2:0] A_PSC_HI = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_TXCMD  = 3'd4;
  localparam logic [2:0] A_TXDATA = 3'd5;
  localparam logic [2:0] A_RXDATA = 3'd6;
  localparam logic [2:0] A_LEVEL  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WRITE, S_READ, S_STOP, S_NAK_STOP, S_POP
  } state_t;

  state_t      state, state_nxt;
  logic        issued, issued_nxt;
  tx_entry_t   cur, cur_nxt;
  logic [3:0]  cmd_nxt;
  logic        trig_nxt;
  logic [7:0]  wdata_nxt;

  logic        en, ie, busy, st_nak, st_al, st_done;
  logic        ie_nxt, busy_nxt, nak_nxt, al_nxt, done_nxt;
  logic [15:0] psc;
  logic [3:0]  txcmd;

  tx_entry_t   tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_count, tx_count_nxt;
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_count, rx_count_nxt;

  logic wr_ctrl, wr_status, wr_txdata, rd_rxdata;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic cpu_flush, dis_abort, al_abort;
  logic fsm_pop, fsm_tx_flush, fsm_rx_push;
  logic set_nak, set_al, set_done, set_busy, clr_busy;
  logic [7:0] rd_mux;
  tx_entry_t tx_head;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{i_wr_addr[1:0], i_rd_addr[1:0]};

  // Register-port decode and FIFO handshakes
  assign wr_ctrl   = i_wr_ena && (i_wr_addr[4:2] == A_CTRL);
  assign wr_status = i_wr_ena && (i_wr_addr[4:2] == A_STATUS);
  assign wr_txdata = i_wr_ena && (i_wr_addr[4:2] == A_TXDATA);
  assign rd_rxdata = i_rd_ena && (i_rd_addr[4:2] == A_RXDATA);

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign tx_head  = tx_mem[tx_rp];

  assign cpu_flush = wr_ctrl && i_wr_data[2];
  assign dis_abort = wr_ctrl && !i_wr_data[0] && (state != S_IDLE);
  assign tx_push   = wr_txdata && !tx_full;
  assign tx_pop    = fsm_pop && !tx_empty;
  assign tx_flush  = cpu_flush || dis_abort || fsm_tx_flush;
  assign rx_push   = fsm_rx_push && !rx_full;
  assign rx_pop    = rd_rxdata && !rx_empty;
  assign rx_flush  = cpu_flush || dis_abort;

  assign o_enable   = en;
  assign o_prescale = psc;

  always_comb begin
    tx_count_nxt = tx_count;
    rx_count_nxt = rx_count;
    if (tx_flush)               tx_count_nxt = '0;
    else if (tx_push && !tx_pop) tx_count_nxt = tx_count + CW'(1);
    else if (!tx_push && tx_pop) tx_count_nxt = tx_count - CW'(1);
    if (rx_flush)               rx_count_nxt = '0;
    else if (rx_push && !rx_pop) rx_count_nxt = rx_count + CW'(1);
    else if (!rx_push && rx_pop) rx_count_nxt = rx_count - CW'(1);
  end

  // FIFO pointers and counts; a flush overrides any same-cycle push or pop
  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
      o_write_ready <= 1'b1;
      o_read_ready  <= 1'b0;
    end else begin
      tx_count <= tx_count_nxt;
      rx_count <= rx_count_nxt;
      o_write_ready <= (tx_count_nxt != FULL_CNT);
      o_read_ready  <= (rx_count_nxt != '0);
      if (tx_flush) begin
        tx_wp <= '0;
        tx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      end
      if (rx_flush) begin
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (tx_push) tx_mem[tx_wp] <= {txcmd, i_wr_data};
    if (rx_push) rx_mem[rx_wp] <= i_rx_data;
  end

  // Sequencer next-state and command outputs
  always_comb begin
    state_nxt    = state;
    issued_nxt   = issued;
    cur_nxt      = cur;
    cmd_nxt      = o_cmd;
    trig_nxt     = 1'b0;
    wdata_nxt    = o_wr_data;
    fsm_pop      = 1'b0;
    fsm_tx_flush = 1'b0;
    fsm_rx_push  = 1'b0;
    al_abort     = 1'b0;
    set_nak      = 1'b0;
    set_al       = 1'b0;
    set_done     = 1'b0;
    set_busy     = 1'b0;
    clr_busy     = 1'b0;
    case (state)
      S_IDLE: begin
        issued_nxt = 1'b0;
        if (en && !tx_empty) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        issued_nxt = 1'b0;
        if (tx_empty) begin
          state_nxt = S_IDLE;
        end else begin
          cur_nxt = tx_head;
          if (tx_head.start)     state_nxt = S_START;
          else if (tx_head.read) state_nxt = S_READ;
          else                   state_nxt = S_WRITE;
        end
      end
      S_START: begin
        if (!issued) begin
          trig_nxt   = 1'b1;
          cmd_nxt    = CMD_START;
          issued_nxt = 1'b1;
        end else if (i_cmd_ack) begin
          issued_nxt = 1'b0;
          cmd_nxt    = CMD_IDLE;
          if (i_i2c_al) begin
            al_abort = 1'b1;
          end else begin
            set_busy  = 1'b1;
            state_nxt = cur.read ? S_READ : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!issued) begin
          trig_nxt   = 1'b1;
          cmd_nxt    = CMD_WRITE;
          wdata_nxt  = cur.data;
          issued_nxt = 1'b1;
        end else if (i_cmd_ack) begin
          issued_nxt = 1'b0;
          cmd_nxt    = CMD_IDLE;
          if (i_i2c_al) begin
            al_abort = 1'b1;
          end else if (i_i2c_ack) begin
            set_nak      = 1'b1;
            fsm_tx_flush = 1'b1;
            state_nxt    = S_NAK_STOP;
          end else begin
            state_nxt = cur.stop ? S_STOP : S_POP;
          end
        end
      end
      S_READ: begin
        // The byte just before STOP is NAKed so the slave releases SDA
        if (!issued) begin
          if (!rx_full) begin
            trig_nxt   = 1'b1;
            cmd_nxt    = (cur.nak || cur.stop) ? CMD_READ_NAK : CMD_READ_ACK;
            issued_nxt = 1'b1;
          end
        end else if (i_cmd_ack) begin
          issued_nxt = 1'b0;
          cmd_nxt    = CMD_IDLE;
          if (i_i2c_al) begin
            al_abort = 1'b1;
          end else begin
            fsm_rx_push = 1'b1;
            state_nxt   = cur.stop ? S_STOP : S_POP;
          end
        end
      end
      S_STOP, S_NAK_STOP: begin
        if (!issued) begin
          trig_nxt   = 1'b1;
          cmd_nxt    = CMD_STOP;
          issued_nxt = 1'b1;
        end else if (i_cmd_ack) begin
          issued_nxt = 1'b0;
          cmd_nxt    = CMD_IDLE;
          clr_busy   = 1'b1;
          if (i_i2c_al)             al_abort  = 1'b1;
          else if (state == S_STOP) state_nxt = S_POP;
          else                      state_nxt = S_IDLE;
        end
      end
      S_POP: begin
        fsm_pop = 1'b1;
        if ((tx_count <= CW'(1)) && !tx_push) begin
          state_nxt = S_IDLE;
          set_done  = 1'b1;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (al_abort) begin
      set_al       = 1'b1;
      fsm_tx_flush = 1'b1;
      clr_busy     = 1'b1;
      state_nxt    = S_IDLE;
    end
    if (dis_abort) begin
      state_nxt  = S_IDLE;
      issued_nxt = 1'b0;
      cmd_nxt    = CMD_IDLE;
      trig_nxt   = 1'b0;
      set_busy   = 1'b0;
      clr_busy   = 1'b1;
    end
  end

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      issued     <= 1'b0;
      cur        <= '0;
      o_cmd      <= CMD_IDLE;
      o_cmd_trig <= 1'b0;
      o_wr_data  <= 8'h00;
    end else begin
      state      <= state_nxt;
      issued     <= issued_nxt;
      cur        <= cur_nxt;
      o_cmd      <= cmd_nxt;
      o_cmd_trig <= trig_nxt;
      o_wr_data  <= wdata_nxt;
    end
  end

  // Sticky status: a hardware set beats a same-cycle W1C
  always_comb begin
    ie_nxt   = wr_ctrl ? i_wr_data[1] : ie;
    nak_nxt  = set_nak  || (st_nak  && !(wr_status && i_wr_data[5]));
    al_nxt   = set_al   || (st_al   && !(wr_status && i_wr_data[6]));
    done_nxt = set_done || (st_done && !(wr_status && i_wr_data[7]));
    busy_nxt = set_busy ? 1'b1 : (clr_busy ? 1'b0 : busy);
  end

  always_comb begin
    rd_mux = 8'h00;
    case (i_rd_addr[4:2])
      A_CTRL:   rd_mux = {6'b0, ie, en};
      A_PSC_LO: rd_mux = psc[7:0];
      A_PSC_HI: rd_mux = psc[15:8];
      A_STATUS: rd_mux = {st_done, st_al, st_nak, rx_empty, rx_full, tx_empty, tx_full, busy};
      A_TXCMD:  rd_mux = {4'b0, txcmd};
      A_RXDATA: rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rp];
      A_LEVEL:  rd_mux = {4'(rx_count), 4'(tx_count)};
      default:  rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en          <= 1'b0;
      ie          <= 1'b0;
      psc         <= PSC_RESET;
      txcmd       <= 4'h0;
      busy        <= 1'b0;
      st_nak      <= 1'b0;
      st_al       <= 1'b0;
      st_done     <= 1'b0;
      o_rd_data   <= 8'h00;
      o_interrupt <= 1'b0;
    end else begin
      if (wr_ctrl) en <= i_wr_data[0];
      if (i_wr_ena && (i_wr_addr[4:2] == A_PSC_LO)) psc[7:0]  <= i_wr_data;
      if (i_wr_ena && (i_wr_addr[4:2] == A_PSC_HI)) psc[15:8] <= i_wr_data;
      if (i_wr_ena && (i_wr_addr[4:2] == A_TXCMD))  txcmd     <= i_wr_data[3:0];
      ie          <= ie_nxt;
      busy        <= busy_nxt;
      st_nak      <= nak_nxt;
      st_al       <= al_nxt;
      st_done     <= done_nxt;
      o_interrupt <= ie_nxt && (done_nxt || nak_nxt || al_nxt);
      if (i_rd_ena) o_rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_i2c_master_fifo_seq.sv
// Bench for i2c_master_fifo_seq: a byte_ctl responder checks each command pulse
// against a queue of expected commands and answers from a queue of responses.
module tb_i2c_master_fifo_seq;

  localparam logic [2:0] R_CTRL = 3'd0, R_PSC_LO = 3'd1, R_PSC_HI = 3'd2, R_STATUS = 3'd3;
  localparam logic [2:0] R_TXCMD = 3'd4, R_TXDATA = 3'd5, R_RXDATA = 3'd6, R_LEVEL = 3'd7;
  localparam logic [3:0] C_IDLE = 4'd0, C_START = 4'd1, C_STOP = 4'd2, C_WRITE = 4'd3;
  localparam logic [3:0] C_RACK = 4'd4, C_RNAK = 4'd5;

  typedef struct { logic [3:0] cmd; logic [7:0] data; } exp_t;
  typedef struct { logic nak; logic al; logic [7:0] rx; } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_ena, rd_ena;
  logic [4:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data, wr_byte, rx_data;
  logic        read_ready, write_ready, irq, enable, cmd_trig;
  logic [15:0] prescale;
  logic [3:0]  cmd;
  logic        cmd_ack, i2c_ack, i2c_al;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  bit    resp_busy = 1'b0;
  bit    force_ack = 1'b0;
  int    n_checks = 0;
  int    n_fails  = 0;

  always #5 clk = ~clk;

  i2c_master_fifo_seq #(.FIFO_DEPTH(8), .PSC_RESET(16'd384)) dut (
    .i_sysclk(clk), .i_reset_n(rst_n),
    .i_wr_ena(wr_ena), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_ena(rd_ena), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_read_ready(read_ready), .o_write_ready(write_ready), .o_interrupt(irq),
    .o_enable(enable), .o_prescale(prescale), .o_cmd(cmd), .o_cmd_trig(cmd_trig),
    .o_wr_data(wr_byte), .i_cmd_ack(cmd_ack), .i_i2c_ack(i2c_ack), .i_i2c_al(i2c_al),
    .i_rx_data(rx_data)
  );

  // byte_ctl model: scoreboard check on each trig, then a delayed ack
  initial begin
    cmd_ack = 1'b0; i2c_ack = 1'b0; i2c_al = 1'b0; rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (cmd_trig === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_trig got cmd %0d data %h required none", cmd, wr_byte);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cmd !== e.cmd || (e.cmd == C_WRITE && wr_byte !== e.data)) begin
            n_fails++;
            $display("FAIL trig_cmd got cmd %0d data %h required cmd %0d data %h", cmd, wr_byte, e.cmd, e.data);
          end
        end
        if (resp_q.size() > 0) begin
          resp_t r;
          resp_busy = 1'b1;
          r = resp_q.pop_front();
          repeat (2) @(negedge clk);
          cmd_ack = 1'b1; i2c_ack = r.nak; i2c_al = r.al; rx_data = r.rx;
          @(negedge clk);
          cmd_ack = 1'b0; i2c_ack = 1'b0; i2c_al = 1'b0;
          resp_busy = 1'b0;
        end
      end else if (force_ack) begin
        force_ack = 1'b0;
        cmd_ack = 1'b1; rx_data = 8'hEE;
        @(negedge clk);
        cmd_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = {r, 2'b00}; wr_data = d;
    @(negedge clk);
    wr_ena = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] r, output logic [7:0] d);
    @(negedge clk);
    rd_ena = 1'b1; rd_addr = {r, 2'b00};
    @(negedge clk);
    rd_ena = 1'b0;
    d = rd_data;
  endtask

  task automatic expect_cmd(input logic [3:0] c, input logic [7:0] d, input logic nak,
                            input logic al, input logic [7:0] rx);
    exp_t e;
    resp_t r;
    e.cmd = c; e.data = d;
    r.nak = nak; r.al = al; r.rx = rx;
    exp_q.push_back(e);
    resp_q.push_back(r);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || resp_q.size() != 0 || resp_busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 400) begin
      n_fails++;
      $display("FAIL %s_timeout got %0d pending commands required 0", tag, exp_q.size());
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    n_checks++; if (rd_data !== 8'h00) begin n_fails++; $display("FAIL reset_rd_data got %h required 00", rd_data); end
    n_checks++; if (cmd !== C_IDLE || cmd_trig !== 1'b0) begin n_fails++; $display("FAIL reset_cmd got %0d/%b required 0/0", cmd, cmd_trig); end
    n_checks++; if (irq !== 1'b0 || enable !== 1'b0) begin n_fails++; $display("FAIL reset_irq_en got %b/%b required 0/0", irq, enable); end
    n_checks++; if (prescale !== 16'h0180) begin n_fails++; $display("FAIL reset_prescale got %h required 0180", prescale); end
    n_checks++; if (write_ready !== 1'b1 || read_ready !== 1'b0) begin n_fails++; $display("FAIL reset_ready got %b/%b required 1/0", write_ready, read_ready); end
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h14) begin n_fails++; $display("FAIL reset_status got %h required 14", d); end
    bus_rd(R_LEVEL, d);
    n_checks++; if (d !== 8'h00) begin n_fails++; $display("FAIL reset_level got %h required 00", d); end
    bus_rd(R_PSC_LO, d);
    n_checks++; if (d !== 8'h80) begin n_fails++; $display("FAIL reset_psc_lo got %h required 80", d); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    bus_wr(R_PSC_LO, 8'h34);
    bus_wr(R_PSC_HI, 8'h12);
    n_checks++; if (prescale !== 16'h1234) begin n_fails++; $display("FAIL psc_out got %h required 1234", prescale); end
    bus_rd(R_PSC_HI, d);
    n_checks++; if (d !== 8'h12) begin n_fails++; $display("FAIL psc_hi_rd got %h required 12", d); end
  endtask

  task automatic test_write();
    logic [7:0] d;
    bus_wr(R_TXCMD, 8'h01); bus_wr(R_TXDATA, 8'hA0);
    bus_wr(R_TXCMD, 8'h02); bus_wr(R_TXDATA, 8'h5A);
    expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00);
    expect_cmd(C_WRITE, 8'hA0, 1'b0, 1'b0, 8'h00);
    expect_cmd(C_WRITE, 8'h5A, 1'b0, 1'b0, 8'h00);
    expect_cmd(C_STOP,  8'h00, 1'b0, 1'b0, 8'h00);
    bus_wr(R_CTRL, 8'h01);
    n_checks++; if (enable !== 1'b1) begin n_fails++; $display("FAIL write_enable got %b required 1", enable); end
    wait_done("write");
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h94) begin n_fails++; $display("FAIL write_status got %h required 94", d); end
    bus_rd(R_LEVEL, d);
    n_checks++; if (d !== 8'h00) begin n_fails++; $display("FAIL write_level got %h required 00", d); end
    bus_wr(R_STATUS, 8'h80);
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h14) begin n_fails++; $display("FAIL done_w1c got %h required 14", d); end
  endtask

  task automatic test_read();
    logic [7:0] d;
    bus_wr(R_CTRL, 8'h00);
    bus_wr(R_TXCMD, 8'h01); bus_wr(R_TXDATA, 8'hA1);
    bus_wr(R_TXCMD, 8'h04); bus_wr(R_TXDATA, 8'h00);
    bus_wr(R_TXCMD, 8'h06); bus_wr(R_TXDATA, 8'h00);
    expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00);
    expect_cmd(C_WRITE, 8'hA1, 1'b0, 1'b0, 8'h00);
    expect_cmd(C_RACK,  8'h00, 1'b0, 1'b0, 8'h11);
    expect_cmd(C_RNAK,  8'h00, 1'b0, 1'b0, 8'h3C);
    expect_cmd(C_STOP,  8'h00, 1'b0, 1'b0, 8'h00);
    bus_wr(R_CTRL, 8'h01);
    wait_done("read");
    n_checks++; if (read_ready !== 1'b1) begin n_fails++; $display("FAIL read_ready got %b required 1", read_ready); end
    bus_rd(R_LEVEL, d);
    n_checks++; if (d !== 8'h20) begin n_fails++; $display("FAIL read_level got %h required 20", d); end
    bus_rd(R_RXDATA, d);
    n_checks++; if (d !== 8'h11) begin n_fails++; $display("FAIL rx_first got %h required 11", d); end
    bus_rd(R_RXDATA, d);
    n_checks++; if (d !== 8'h3C) begin n_fails++; $display("FAIL rx_second got %h required 3c", d); end
    bus_rd(R_RXDATA, d);
    n_checks++; if (d !== 8'h00) begin n_fails++; $display("FAIL rx_empty_read got %h required 00", d); end
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h94) begin n_fails++; $display("FAIL read_status got %h required 94", d); end
    bus_wr(R_STATUS, 8'h80);
  endtask

  task automatic test_nak();
    logic [7:0] d;
    bus_wr(R_CTRL, 8'h02);
    bus_wr(R_TXCMD, 8'h01); bus_wr(R_TXDATA, 8'hA0);
    bus_wr(R_TXCMD, 8'h00); bus_wr(R_TXDATA, 8'h11);
    bus_wr(R_TXCMD, 8'h02); bus_wr(R_TXDATA, 8'h22);
    expect_cmd(C_START, 8'h00, 1'b0, 1'b0, 8'h00);
    expect_cmd(C_WRITE, 8'hA0, 1'b1, 1'b0, 8'h00);
    expect_cmd(C_STOP,  8'h00, 1'b0, 1'b0, 8'h00);
    bus_wr(R_CTRL, 8'h03);
    wait_done("nak");
    bus_rd(R_LEVEL, d);
    n_checks++; if (d !== 8'h00) begin n_fails++; $display("FAIL nak_level got %h required 00", d); end
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h34) begin n_fails++; $display("FAIL nak_status got %h required 34", d); end
    n_checks++; if (irq !== 1'b1) begin n_fails++; $display("FAIL nak_irq got %b required 1", irq); end
    bus_wr(R_STATUS, 8'h20);
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fails++; $display("FAIL nak_irq_clear got %b required 0", irq); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d;
    bus_wr(R_CTRL, 8'h02);
    bus_wr(R_TXCMD, 8'h00);
    for (int i = 0; i < 9; i++) bus_wr(R_TXDATA, 8'hB0 + 8'(i));
    bus_rd(R_LEVEL, d);
    n_checks++; if (d !== 8'h08) begin n_fails++; $display("FAIL full_level got %h required 08", d); end
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h12) begin n_fails++; $display("FAIL full_status got %h required 12", d); end
    n_checks++; if (write_ready !== 1'b0) begin n_fails++; $display("FAIL full_write_ready got %b required 0", write_ready); end
    for (int i = 0; i < 8; i++) expect_cmd(C_WRITE, 8'hB0 + 8'(i), 1'b0, 1'b0, 8'h00);
    bus_wr(R_CTRL, 8'h03);
    wait_done("full");
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h94) begin n_fails++; $display("FAIL full_drain_status got %h required 94", d); end
    n_checks++; if (irq !== 1'b1 || write_ready !== 1'b1) begin n_fails++; $display("FAIL full_drain_irq_ready got %b/%b required 1/1", irq, write_ready); end
    bus_wr(R_STATUS, 8'h80);
    bus_wr(R_CTRL, 8'h00);
  endtask

  task automatic test_al();
    logic [7:0] d;
    bus_wr(R_TXCMD, 8'h01); bus_wr(R_TXDATA, 8'hA0);
    bus_wr(R_TXCMD, 8'h02); bus_wr(R_TXDATA, 8'h5A);
    expect_cmd(C_START, 8'h00, 1'b0, 1'b1, 8'h00);
    bus_wr(R_CTRL, 8'h01);
    wait_done("al");
    repeat (10) @(negedge clk);
    bus_rd(R_LEVEL, d);
    n_checks++; if (d !== 8'h00) begin n_fails++; $display("FAIL al_level got %h required 00", d); end
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h54) begin n_fails++; $display("FAIL al_status got %h required 54", d); end
    bus_wr(R_STATUS, 8'h40);
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h14) begin n_fails++; $display("FAIL al_w1c got %h required 14", d); end
  endtask

  task automatic test_en_clear();
    logic [7:0] d;
    exp_t e;
    int k = 0;
    bus_wr(R_CTRL, 8'h00);
    bus_wr(R_TXCMD, 8'h04); bus_wr(R_TXDATA, 8'h77);
    e.cmd = C_RACK; e.data = 8'h00;
    exp_q.push_back(e);
    bus_wr(R_CTRL, 8'h01);
    while (exp_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
    n_checks++; if (k >= 100) begin n_fails++; $display("FAIL enclr_trig_timeout got no trig required READ_ACK"); end
    repeat (3) @(negedge clk);
    bus_wr(R_CTRL, 8'h00);
    n_checks++; if (cmd !== C_IDLE || cmd_trig !== 1'b0) begin n_fails++; $display("FAIL enclr_cmd got %0d/%b required 0/0", cmd, cmd_trig); end
    force_ack = 1'b1;
    repeat (10) @(negedge clk);
    bus_rd(R_LEVEL, d);
    n_checks++; if (d !== 8'h00) begin n_fails++; $display("FAIL enclr_level got %h required 00", d); end
    bus_rd(R_STATUS, d);
    n_checks++; if (d !== 8'h14) begin n_fails++; $display("FAIL enclr_status got %h required 14", d); end
    n_checks++; if (read_ready !== 1'b0) begin n_fails++; $display("FAIL enclr_read_ready got %b required 0", read_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_ena = 1'b0; wr_addr = 5'h00; wr_data = 8'h00;
    rd_ena = 1'b0; rd_addr = 5'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_regs();
    test_write();
    test_read();
    test_nak();
    test_fifo_full();
    test_al();
    test_en_clear();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL leftover_cmds got %0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
